// File: rtl/cpu_instr_pkg.sv
// cpu_instr_pkg: shared constants for the instruction sequencer.
//   - opcode values of the 4-bit opcode field
//   - bit positions of the instruction fields (control fields decoded here,
//     executor fields passed through untouched)
//   - FSM state encoding and GUARD length
//   - is_parked(): true for states that accept a start
package cpu_instr_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_PLAY = 4'd1;
  localparam logic [3:0] OP_JUMP = 4'd2;
  localparam logic [3:0] OP_LOOP = 4'd3;
  localparam logic [3:0] OP_HALT = 4'd4;

  localparam int OPC_LSB  = 0;
  localparam int OPC_MSB  = 3;
  localparam int TGT_LSB  = 112;
  localparam int CNT_LSB  = 32;
  localparam int CNT_MSB  = 47;
  // Executor-owned PLAY fields; never interpreted by the sequencer.
  localparam int ADDR_LSB = 64;
  localparam int ADDR_MSB = 96;
  localparam int LEN_LSB  = 32;
  localparam int LEN_MSB  = 57;
  localparam int SEGT_LSB = 4;
  localparam int SEGT_MSB = 19;

  localparam int GUARD_CYCLES = 2;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_FETCH     = 4'd1;
  localparam logic [3:0] ST_RDWAIT    = 4'd2;
  localparam logic [3:0] ST_DECODE    = 4'd3;
  localparam logic [3:0] ST_ISSUE     = 4'd4;
  localparam logic [3:0] ST_GUARD     = 4'd5;
  localparam logic [3:0] ST_WAIT_EXEC = 4'd6;
  localparam logic [3:0] ST_HALTED    = 4'd7;
  localparam logic [3:0] ST_ERROR     = 4'd8;

  // States where the sequencer is not running and a start is accepted.
  function automatic logic is_parked(input logic [3:0] st);
    return (st == ST_IDLE) || (st == ST_HALTED) || (st == ST_ERROR);
  endfunction

endpackage

// File: rtl/cpu_instr_fetch_loop_ctrl.sv
// cpu_loop_ctrl: single-level hardware loop state for the LOOP opcode.
// Ports:
//   clk, rst     clock, async active-high reset
//   clear        drop loop state (stop, or a new start being accepted)
//   loop_dec     a LOOP instruction is being decoded this cycle
//   count        LOOP count field of that instruction
//   take_branch  LOOP must jump to its target (combinational)
module cpu_loop_ctrl
  import cpu_instr_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         loop_dec,
  input  logic [CNT_MSB-CNT_LSB:0]     count,
  output logic                         take_branch
);

  localparam int CNT_W = CNT_MSB - CNT_LSB + 1;

  logic             loop_active;
  logic [CNT_W-1:0] loop_cnt;

  // Branch decision: first pass arms the loop, later passes use the remaining count.
  always_comb begin
    take_branch = 1'b0;
    if (loop_dec) begin
      if (!loop_active) begin
        take_branch = (count != {CNT_W{1'b0}});
      end else begin
        take_branch = (loop_cnt != {CNT_W{1'b0}});
      end
    end else begin
      take_branch = 1'b0;
    end
  end

  // Loop counter: count N gives N jumps back, then the loop disarms itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loop_active <= 1'b0;
      loop_cnt    <= {CNT_W{1'b0}};
    end else if (clear) begin
      loop_active <= 1'b0;
      loop_cnt    <= {CNT_W{1'b0}};
    end else if (loop_dec) begin
      if (!loop_active && (count != {CNT_W{1'b0}})) begin
        loop_cnt    <= count - {{(CNT_W-1){1'b0}}, 1'b1};
        loop_active <= 1'b1;
      end else if (loop_active && (loop_cnt != {CNT_W{1'b0}})) begin
        loop_cnt    <= loop_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        loop_active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cpu_instr_fetch.sv
// cpu_instr_fetch: instruction sequencer in front of the waveform executor.
// Fetches 128-bit instructions from a 1-cycle-latency RAM, executes
// NOP/JUMP/LOOP/HALT locally and hands PLAY instructions to the executor.
// Ports:
//   clk, rst            clock, async active-high reset
//   start, stop         run request (needs exec_done) / abort to IDLE
//   start_pc            first instruction address
//   imem_en, imem_addr  RAM read request; imem_rdata valid one cycle later
//   instr_out           last issued PLAY, held until the next issue
//   instr_valid         one-cycle issue strobe
//   exec_done           executor idle level
//   busy, halted, err_opcode, cur_pc   status
module cpu_instr_fetch
  import cpu_instr_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int INSTR_W = 128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [ADDR_W-1:0]  start_pc,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  input  logic               exec_done,
  output logic               busy,
  output logic               halted,
  output logic               err_opcode,
  output logic [ADDR_W-1:0]  cur_pc
);

  localparam logic [1:0] GUARD_LAST = 2'(GUARD_CYCLES - 1);

  logic [3:0]         state;
  logic [3:0]         state_next;
  logic [3:0]         state_fsm;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  pc_next;
  logic [ADDR_W-1:0]  pc_fsm;
  logic [ADDR_W-1:0]  pc_inc;
  logic [INSTR_W-1:0] ir;
  logic [1:0]         guard_cnt;
  logic [3:0]         opcode;
  logic [ADDR_W-1:0]  target;
  logic               start_ok;
  logic               loop_dec;
  logic               take_branch;

  assign opcode    = ir[OPC_MSB:OPC_LSB];
  assign target    = ir[TGT_LSB +: ADDR_W];
  assign pc_inc    = pc + {{(ADDR_W-1){1'b0}}, 1'b1};  // wraps silently
  assign start_ok  = is_parked(state) && start && exec_done && !stop;
  assign loop_dec  = (state == ST_DECODE) && (opcode == OP_LOOP) && !stop;
  assign imem_addr = pc;
  assign cur_pc    = pc;

  cpu_loop_ctrl u_loop_ctrl (
    .clk         (clk),
    .rst         (rst),
    .clear       (stop || start_ok),
    .loop_dec    (loop_dec),
    .count       (ir[CNT_MSB:CNT_LSB]),
    .take_branch (take_branch)
  );

  // Sequencing decisions, before stop is applied.
  always_comb begin
    state_fsm = state;
    pc_fsm    = pc;
    case (state)
      ST_IDLE, ST_HALTED, ST_ERROR: begin
        if (start_ok) begin
          state_fsm = ST_FETCH;
          pc_fsm    = start_pc;
        end else begin
          state_fsm = state;
        end
      end
      ST_FETCH:  state_fsm = ST_RDWAIT;
      ST_RDWAIT: state_fsm = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_NOP: begin
            pc_fsm    = pc_inc;
            state_fsm = ST_FETCH;
          end
          OP_PLAY: state_fsm = ST_ISSUE;
          OP_JUMP: begin
            pc_fsm    = target;
            state_fsm = ST_FETCH;
          end
          OP_LOOP: begin
            pc_fsm    = take_branch ? target : pc_inc;
            state_fsm = ST_FETCH;
          end
          OP_HALT: state_fsm = ST_HALTED;
          default: state_fsm = ST_ERROR;
        endcase
      end
      ST_ISSUE: state_fsm = ST_GUARD;
      // exec_done is stale for a couple of cycles after issue, so ignore it here.
      ST_GUARD: begin
        if (guard_cnt == GUARD_LAST) begin
          state_fsm = ST_WAIT_EXEC;
        end else begin
          state_fsm = ST_GUARD;
        end
      end
      ST_WAIT_EXEC: begin
        if (exec_done) begin
          pc_fsm    = pc_inc;
          state_fsm = ST_FETCH;
        end else begin
          state_fsm = ST_WAIT_EXEC;
        end
      end
      default: state_fsm = ST_IDLE;
    endcase
  end

  // stop overrides every transition and freezes the PC.
  always_comb begin
    state_next = state_fsm;
    pc_next    = pc_fsm;
    if (stop) begin
      state_next = ST_IDLE;
      pc_next    = pc;
    end else begin
      state_next = state_fsm;
      pc_next    = pc_fsm;
    end
  end

  // State and program counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      pc    <= {ADDR_W{1'b0}};
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // GUARD dwell counter, restarted whenever GUARD is not active.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      guard_cnt <= 2'd0;
    end else if (state == ST_GUARD) begin
      guard_cnt <= guard_cnt + 2'd1;
    end else begin
      guard_cnt <= 2'd0;
    end
  end

  // Instruction register: RAM data is valid during RDWAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir <= {INSTR_W{1'b0}};
    end else if (state == ST_RDWAIT) begin
      ir <= imem_rdata;
    end
  end

  // Registered outputs, decoded from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_en     <= 1'b0;
      instr_valid <= 1'b0;
      instr_out   <= {INSTR_W{1'b0}};
      busy        <= 1'b0;
      halted      <= 1'b0;
      err_opcode  <= 1'b0;
    end else begin
      imem_en     <= (state_next == ST_FETCH);
      instr_valid <= (state_next == ST_ISSUE);
      busy        <= !is_parked(state_next);
      halted      <= (state_next == ST_HALTED);
      err_opcode  <= (state_next == ST_ERROR);
      if (state_next == ST_ISSUE) begin
        instr_out <= ir;
      end
    end
  end

endmodule

// File: tb/tb_cpu_instr_fetch.sv
// Directed bench for cpu_instr_fetch with a synchronous RAM model and a
// simple executor model (exec_done low for segt*8 beats after each issue).
module tb_cpu_instr_fetch;

  localparam int ADDR_W = 10;

  logic               clk;
  logic               rst;
  logic               start;
  logic               stop;
  logic [ADDR_W-1:0]  start_pc;
  logic               imem_en;
  logic [ADDR_W-1:0]  imem_addr;
  logic [127:0]       imem_rdata;
  logic [127:0]       instr_out;
  logic               instr_valid;
  logic               exec_done;
  logic               busy;
  logic               halted;
  logic               err_opcode;
  logic [ADDR_W-1:0]  cur_pc;

  int checks;
  int errors;

  logic [127:0] mem [0:1023];
  bit           exec_auto;
  int           beats;
  int           pulses;
  logic [127:0] issued [$];
  int           fetch_q [$];

  cpu_instr_fetch #(.ADDR_W(ADDR_W), .INSTR_W(128)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .start_pc(start_pc),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr_out(instr_out), .instr_valid(instr_valid), .exec_done(exec_done),
    .busy(busy), .halted(halted), .err_opcode(err_opcode), .cur_pc(cur_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous instruction RAM, one cycle read latency
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem[imem_addr];
  end

  // issue / fetch monitor
  initial begin
    pulses = 0;
    forever begin
      @(negedge clk);
      if (instr_valid === 1'b1) begin
        pulses++;
        issued.push_back(instr_out);
      end
      if (imem_en === 1'b1) fetch_q.push_back(int'(imem_addr));
    end
  end

  // executor model
  initial begin
    beats = 0;
    forever begin
      @(negedge clk);
      if (exec_auto) begin
        if (instr_valid === 1'b1) begin
          beats = 8 * int'(instr_out[19:4]);
          if (beats != 0) exec_done = 1'b0;
        end else if (beats > 0) begin
          beats--;
          if (beats == 0) exec_done = 1'b1;
        end
      end
    end
  end

  function automatic logic [127:0] mk_play(input logic [15:0] segt, input logic [32:0] addr);
    logic [127:0] r;
    r = 128'd0;
    r[3:0]   = 4'd1;
    r[19:4]  = segt;
    r[57:32] = 26'h2A5_5A5;
    r[96:64] = addr;
    return r;
  endfunction

  function automatic logic [127:0] mk_ctl(input logic [3:0] op, input logic [9:0] tgt, input logic [15:0] cnt);
    logic [127:0] r;
    r = 128'd0;
    r[3:0]     = op;
    r[121:112] = tgt;
    r[47:32]   = cnt;
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] pc);
    start_pc = pc;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_parked(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (halted === 1'b1 || err_opcode === 1'b1) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_exec_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (exec_done === 1'b1) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    bit ok;
    int p0, q0, f0, vi, fi;
    checks = 0; errors = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 128'd0;
    rst = 1'b1; start = 1'b0; stop = 1'b0; start_pc = 10'd0;
    exec_done = 1'b1; exec_auto = 1'b1;

    // reset values
    tick(2);
    check("rst_busy", busy, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_err", err_opcode, 1'b0);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_imem_en", imem_en, 1'b0);
    check("rst_pc", cur_pc, 10'd0);
    check("rst_instr_out", instr_out, 128'd0);
    rst = 1'b0;
    tick(1);

    // straight-line program
    mem[0] = mk_play(16'd3, 33'h1_0000_0011);
    mem[1] = mk_play(16'd1, 33'h0_0000_0022);
    mem[2] = mk_ctl(4'd4, 10'd0, 16'd0);
    p0 = pulses; q0 = issued.size();
    pulse_start(10'd0);
    check("t1_busy_running", busy, 1'b1);
    wait_parked(400, ok);
    check("t1_finished", ok, 1'b1);
    check("t1_pulses", pulses - p0, 2);
    check("t1_instr0", issued[q0], mem[0]);
    check("t1_instr1", issued[q0+1], mem[1]);
    check("t1_halted", halted, 1'b1);
    check("t1_busy", busy, 1'b0);

    // loop: PLAY, LOOP(target 0, count 2), HALT -> 3 issues, twice
    mem[0] = mk_play(16'd1, 33'h0_0000_0033);
    mem[1] = mk_ctl(4'd3, 10'd0, 16'd2);
    mem[2] = mk_ctl(4'd4, 10'd0, 16'd0);
    p0 = pulses;
    pulse_start(10'd0);
    wait_parked(600, ok);
    check("t2_finished", ok, 1'b1);
    check("t2_pulses", pulses - p0, 3);
    check("t2_halted", halted, 1'b1);
    p0 = pulses;
    pulse_start(10'd0);
    wait_parked(600, ok);
    check("t2_finished_again", ok, 1'b1);
    check("t2_pulses_again", pulses - p0, 3);

    // NOP at top of memory wraps to 0, JUMP to 5, HALT
    mem[1023] = mk_ctl(4'd0, 10'd0, 16'd0);
    mem[0]    = mk_ctl(4'd2, 10'd5, 16'd0);
    mem[5]    = mk_ctl(4'd4, 10'd0, 16'd0);
    p0 = pulses; f0 = fetch_q.size();
    pulse_start(10'd1023);
    wait_parked(100, ok);
    check("t3_finished", ok, 1'b1);
    check("t3_nfetch", fetch_q.size() - f0, 3);
    check("t3_fetch0", fetch_q[f0], 1023);
    check("t3_fetch1", fetch_q[f0+1], 0);
    check("t3_fetch2", fetch_q[f0+2], 5);
    check("t3_pc", cur_pc, 10'd5);
    check("t3_halted", halted, 1'b1);
    check("t3_pulses", pulses - p0, 0);

    // illegal opcode, then restart from ERROR
    mem[3] = mk_ctl(4'hF, 10'd0, 16'd0);
    p0 = pulses;
    pulse_start(10'd3);
    wait_parked(100, ok);
    check("t4_stopped", ok, 1'b1);
    check("t4_err", err_opcode, 1'b1);
    check("t4_busy", busy, 1'b0);
    check("t4_halted", halted, 1'b0);
    check("t4_pulses", pulses - p0, 0);
    f0 = fetch_q.size();
    pulse_start(10'd5);
    wait_parked(100, ok);
    check("t4_restart_fetch", fetch_q[f0], 5);
    check("t4_restart_err", err_opcode, 1'b0);
    check("t4_restart_halted", halted, 1'b1);

    // stop during WAIT_EXEC
    mem[0] = mk_play(16'd4, 33'h0_0000_0044);
    mem[1] = mk_ctl(4'd4, 10'd0, 16'd0);
    p0 = pulses;
    pulse_start(10'd0);
    for (int i = 0; i < 20 && pulses == p0; i++) @(negedge clk);
    check("t5_issued", pulses - p0, 1);
    tick(6);
    check("t5_busy_wait", busy, 1'b1);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    check("t5_stop_busy", busy, 1'b0);
    check("t5_stop_halted", halted, 1'b0);
    check("t5_stop_valid", instr_valid, 1'b0);
    check("t5_stop_instr_out", instr_out, mem[0]);
    check("t5_stop_pc", cur_pc, 10'd0);
    wait_exec_idle(60, ok);
    check("t5_exec_idle", ok, 1'b1);
    tick(2);
    check("t5_no_refetch", pulses - p0, 1);

    // stop in the same cycle as DECODE of a PLAY
    pulse_start(10'd0);  // FETCH
    tick(2);             // RDWAIT, DECODE
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    check("t5d_busy", busy, 1'b0);
    check("t5d_valid", instr_valid, 1'b0);
    tick(3);
    check("t5d_pulses", pulses - p0, 1);

    // start while exec_done is low is ignored
    exec_auto = 1'b0;
    exec_done = 1'b0;
    f0 = fetch_q.size();
    pulse_start(10'd0);
    tick(4);
    check("t5s_busy", busy, 1'b0);
    check("t5s_nfetch", fetch_q.size() - f0, 0);
    exec_done = 1'b1;
    exec_auto = 1'b1;
    tick(1);

    // segt=0 PLAY: issue at cycle 4, next fetch at cycle 8 (2 GUARD + 1 WAIT_EXEC)
    mem[0] = mk_play(16'd0, 33'h0_0000_0055);
    mem[1] = mk_ctl(4'd4, 10'd0, 16'd0);
    vi = 0; fi = 0;
    pulse_start(10'd0);
    for (int i = 2; i <= 12; i++) begin
      @(negedge clk);
      if (instr_valid === 1'b1 && vi == 0) vi = i;
      if (imem_en === 1'b1 && imem_addr == 10'd1 && fi == 0) fi = i;
    end
    check("t6_issue_cycle", vi, 4);
    check("t6_next_fetch_cycle", fi, 8);
    wait_parked(50, ok);
    check("t6_halted", halted, 1'b1);

    // async reset while in GUARD
    pulse_start(10'd0);
    tick(4);
    check("t6_busy_guard", busy, 1'b1);
    check("t6_instr_out_guard", instr_out, mem[0]);
    rst = 1'b1;
    #1;
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_instr_out", instr_out, 128'd0);
    check("t6_rst_pc", cur_pc, 10'd0);
    check("t6_rst_imem_en", imem_en, 1'b0);
    check("t6_rst_valid", instr_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    p0 = pulses;
    tick(6);
    check("t6_post_rst_pulses", pulses - p0, 0);
    check("t6_post_rst_busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cpu_instr_fetch.md
Name: cpu_instr_fetch

Overview:
- Instruction sequencer sitting directly upstream of the waveform command executor.
- Fetches 128-bit instructions from a synchronous instruction RAM and decodes control opcodes (JUMP/LOOP/HALT) locally.
- Hands each PLAY instruction to the executor as a single-cycle instr_valid pulse, then waits for the executor's generate_done before fetching the next.

Parameters:
- ADDR_W, 10, instruction RAM address width; PC wraps modulo 2^ADDR_W.
- INSTR_W, 128, instruction width; fixed at 128, not to be overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  pulse; begin execution at start_pc.
- stop  in  1  pulse; abort and return to IDLE.
- start_pc  in  ADDR_W  first instruction address.
- imem_en  out  1  RAM read enable.
- imem_addr  out  ADDR_W  RAM read address.
- imem_rdata  in  128  RAM read data; valid 1 cycle after imem_en.
- instr_out  out  128  instruction to executor; held stable after issue until the next issue.
- instr_valid  out  1  1-cycle issue strobe to executor.
- exec_done  in  1  executor generate_done (level).
- busy  out  1  high in any state except IDLE, HALTED, ERROR.
- halted  out  1  high in HALTED.
- err_opcode  out  1  high in ERROR.
- cur_pc  out  ADDR_W  current PC.

Behaviour:
- Reset values: all outputs 0, pc=0, loop_active=0, loop_cnt=0, state=IDLE.
- Instruction format:
  - opcode=[3:0]: 0 NOP, 1 PLAY, 2 JUMP, 3 LOOP, 4 HALT; all others illegal.
  - PLAY: fields [96:64], [57:32], [19:4] are consumed by the executor and passed through unmodified.
  - JUMP/LOOP: target=[112+ADDR_W-1:112], count=[47:32] (16 bit).
- FSM states: IDLE, FETCH, RDWAIT, DECODE, ISSUE, GUARD, WAIT_EXEC, HALTED, ERROR.
- IDLE/HALTED/ERROR → FETCH: on start && exec_done && !stop; pc<=start_pc, loop_active<=0. Start is ignored otherwise.
- FETCH: imem_en=1, imem_addr=pc; → RDWAIT.
- RDWAIT: → DECODE; capture imem_rdata into ir at the end of this cycle.
- DECODE (one cycle):
  - NOP: pc<=pc+1 → FETCH.
  - PLAY: → ISSUE.
  - JUMP: pc<=target → FETCH.
  - LOOP:
    - !loop_active && count!=0: loop_cnt<=count-1, loop_active<=1, pc<=target.
    - loop_active && loop_cnt!=0: loop_cnt<=loop_cnt-1, pc<=target.
    - Otherwise: loop_active<=0, pc<=pc+1.
    - All cases → FETCH. A LOOP with count N causes N jumps back, so the body runs N+1 times. One loop level only; nesting is not supported.
  - HALT: → HALTED.
  - Illegal opcode: → ERROR.
- ISSUE: instr_out<=ir, instr_valid=1 for exactly this cycle; → GUARD.
- GUARD: 2-cycle counter that ignores exec_done, covering the executor's reaction latency; → WAIT_EXEC.
- WAIT_EXEC: when exec_done==1, pc<=pc+1 → FETCH. A PLAY with segment_times=0 therefore completes right after GUARD.
- PLAY-to-PLAY issue spacing is at least 7 cycles (ISSUE, GUARD×2, WAIT_EXEC≥1, FETCH, RDWAIT, DECODE).
- PC increment wraps from 2^ADDR_W-1 to 0 silently.
- stop in any state → IDLE on the next edge:
  - instr_valid is never asserted in that cycle.
  - loop state is cleared.
  - instr_out keeps its last value.
  - stop has priority over start and over every transition.
- rst mid-operation: immediate return to reset values; no pending issue survives.

Decomposition:
- Shared package cpu_instr_pkg holds:
  - opcode constants OP_NOP..OP_HALT.
  - field bit positions: OPC_LSB/MSB, TGT_LSB, CNT_LSB/MSB, and the executor fields ADDR_LSB/MSB, LEN_LSB/MSB, SEGT_LSB/MSB.
  - FSM state encoding.
  - GUARD_CYCLES=2.
- One natural sub-module, cpu_loop_ctrl: holds loop_active/loop_cnt and outputs take_branch for the LOOP decode.

Test Plan:
- Straight-line program: start_pc=0; RAM[0]=PLAY (segt=3), RAM[1]=PLAY (segt=1), RAM[2]=HALT; executor model drops exec_done for 3×8 and 1×8 beats → exactly two instr_valid pulses, instr_out matches RAM[0] then RAM[1], then halted=1 and busy=0.
- Loop: RAM[0]=PLAY, RAM[1]=LOOP (target=0, count=2), RAM[2]=HALT → 3 PLAY issues, then halted; a second start runs 3 more, proving loop_active was cleared.
- JUMP and wrap: ADDR_W=10, start_pc=1023, RAM[1023]=NOP, RAM[0]=JUMP (target=5), RAM[5]=HALT → cur_pc sequence 1023, 0, 5; halted=1.
- Illegal opcode 4'hF at pc=3 → err_opcode=1, no instr_valid; start with exec_done=1 → restarts from start_pc.
- stop asserted during WAIT_EXEC and again in the same cycle as DECODE of a PLAY → IDLE next cycle, no instr_valid pulse; start while exec_done=0 is ignored.
- Async rst mid-GUARD → all outputs 0 within the same cycle; a PLAY with segt=0 completes after exactly 2 GUARD cycles plus 1 WAIT_EXEC cycle.
